// File: rtl/riscv_exec_pkg.sv
// Shared definitions for the RV32IM execute stage: ALU op codes, branch and
// M-extension funct3 codes, forwarding selects and the MDU state encoding.
package riscv_exec_pkg;

  // ALUControl_E encodings; codes 10-15 yield zero
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  // Branch condition funct3
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  // RV32M funct3
  localparam logic [2:0] M_MUL    = 3'd0;
  localparam logic [2:0] M_MULH   = 3'd1;
  localparam logic [2:0] M_MULHSU = 3'd2;
  localparam logic [2:0] M_MULHU  = 3'd3;
  localparam logic [2:0] M_DIV    = 3'd4;
  localparam logic [2:0] M_DIVU   = 3'd5;
  localparam logic [2:0] M_REM    = 3'd6;
  localparam logic [2:0] M_REMU   = 3'd7;

  // Forwarding mux selects
  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_ZERO = 2'b11;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   start        launch an op when idle (operands latched on that edge)
//   op           RV32M funct3
//   a, b         operands (rs1, rs2)
//   busy         iterating (RUN)
//   done         result valid this cycle (DONE)
//   result       signed-corrected result, valid while done=1
module mdu_iterative
  import riscv_exec_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  mdu_state_t      state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  // Multiply: hi = partial product, lo = multiplier shifting out, m = multiplicand.
  // Divide:   hi = partial remainder, lo = dividend/quotient, m = divisor.
  logic [XLEN-1:0] hi, lo, m;
  logic            neg_q, neg_r, div0;

  logic            is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic            div_ge;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quo, rem;

  always_comb begin
    is_div   = op[2];
    a_signed = is_div ? ~op[0] : ((op == M_MULH) || (op == M_MULHSU));
    b_signed = is_div ? ~op[0] : (op == M_MULH);
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
  end

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    div_shift = {hi, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, m};
    div_ge    = (div_shift >= {1'b0, m});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= MDU_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      hi    <= '0;
      lo    <= '0;
      m     <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (start) begin
            state <= MDU_RUN;
            cnt   <= '0;
            op_q  <= op;
            hi    <= '0;
            lo    <= is_div ? a_mag : b_mag;
            m     <= is_div ? b_mag : a_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            div0  <= (b == '0);
          end
        end
        MDU_RUN: begin
          if (op_q[2]) begin
            hi <= div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo <= {lo[XLEN-2:0], div_ge};
          end else begin
            hi <= mul_sum[XLEN:1];
            lo <= {mul_sum[0], lo[XLEN-1:1]};
          end
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) state <= MDU_DONE;
        end
        MDU_DONE: state <= MDU_IDLE;
        default:  state <= MDU_IDLE;
      endcase
    end
  end

  // Divide by zero leaves the quotient magnitude all ones; the sign fix-up
  // would corrupt that, so it is forced. Remainder = dividend falls out naturally.
  always_comb begin
    prod   = {hi, lo};
    prod_s = neg_q ? -prod : prod;
    quo    = div0 ? '1 : (neg_q ? -lo : lo);
    rem    = neg_r ? -hi : hi;
    case (op_q)
      M_MUL:                    result = prod_s[XLEN-1:0];
      M_MULH, M_MULHSU, M_MULHU: result = prod_s[2*XLEN-1:XLEN];
      M_DIV, M_DIVU:            result = quo;
      default:                  result = rem;
    endcase
  end

  assign busy = (state == MDU_RUN);
  assign done = (state == MDU_DONE);

endmodule

// File: rtl/execute_stage_mdu.sv
// RV32IM execute stage: forwarding muxes, ALU, branch/jump resolution,
// iterative MDU and the E->M pipeline register.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   *_E control/data inputs        from the ID/EX register and hazard unit
//   ResultW                        writeback value for forwarding
//   PCSrc_E, PC_Target_E           PC redirect
//   Stall_E                        hold F/D/E while the MDU works
//   *_M outputs                    E/M pipeline register
module execute_stage_mdu
  import riscv_exec_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWrite_E,
  input  logic            MemWrite_E,
  input  logic            ALUSrc_E,
  input  logic            Branch_E,
  input  logic            Jump_E,
  input  logic            Jalr_E,
  input  logic            MulDiv_E,
  input  logic [1:0]      ResultSrc_E,
  input  logic [3:0]      ALUControl_E,
  input  logic [2:0]      funct3_E,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [XLEN-1:0] PC_E,
  input  logic [XLEN-1:0] PCPlus4_E,
  input  logic [XLEN-1:0] ResultW,
  input  logic [REGW-1:0] RD_E,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  output logic            PCSrc_E,
  output logic [XLEN-1:0] PC_Target_E,
  output logic            Stall_E,
  output logic            RegWrite_M,
  output logic            MemWrite_M,
  output logic [1:0]      ResultSrc_M,
  output logic [REGW-1:0] RD_M,
  output logic [XLEN-1:0] PCPlus4_M,
  output logic [XLEN-1:0] WriteData_M,
  output logic [XLEN-1:0] ALU_Result_M
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [XLEN-1:0] src_a, src_b_int, src_b, alu_result, jalr_sum, mdu_result;
  logic [SHW-1:0]  shamt;
  logic            br_eq, br_lt, br_ltu, br_cond;
  logic            mdu_busy, mdu_done;

  always_comb begin
    case (ForwardA_E)
      FWD_RF:  src_a = RD1_E;
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = ALU_Result_M;
      default: src_a = '0;
    endcase
    case (ForwardB_E)
      FWD_RF:  src_b_int = RD2_E;
      FWD_WB:  src_b_int = ResultW;
      FWD_MEM: src_b_int = ALU_Result_M;
      default: src_b_int = '0;
    endcase
    src_b = ALUSrc_E ? Imm_Ext_E : src_b_int;
    shamt = src_b[SHW-1:0];
  end

  always_comb begin
    case (ALUControl_E)
      ALU_ADD:  alu_result = src_a + src_b;
      ALU_SUB:  alu_result = src_a - src_b;
      ALU_AND:  alu_result = src_a & src_b;
      ALU_OR:   alu_result = src_a | src_b;
      ALU_XOR:  alu_result = src_a ^ src_b;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
      ALU_SLL:  alu_result = src_a << shamt;
      ALU_SRL:  alu_result = src_a >> shamt;
      ALU_SRA:  alu_result = XLEN'($signed(src_a) >>> shamt);
      default:  alu_result = '0;
    endcase
  end

  // Branch compare uses the register operand, never the immediate
  always_comb begin
    br_eq  = (src_a == src_b_int);
    br_lt  = ($signed(src_a) < $signed(src_b_int));
    br_ltu = (src_a < src_b_int);
    case (funct3_E)
      BR_BEQ:  br_cond = br_eq;
      BR_BNE:  br_cond = ~br_eq;
      BR_BLT:  br_cond = br_lt;
      BR_BGE:  br_cond = ~br_lt;
      BR_BLTU: br_cond = br_ltu;
      BR_BGEU: br_cond = ~br_ltu;
      default: br_cond = 1'b0;
    endcase
    jalr_sum    = src_a + Imm_Ext_E;
    PC_Target_E = Jalr_E ? {jalr_sum[XLEN-1:1], 1'b0} : (PC_E + Imm_Ext_E);
    PCSrc_E     = ~MulDiv_E & (Jump_E | (Branch_E & br_cond));
  end

  mdu_iterative #(
    .XLEN(XLEN)
  ) u_mdu (
    .clk   (clk),
    .rst   (rst),
    .start (MulDiv_E),
    .op    (funct3_E),
    .a     (src_a),
    .b     (src_b_int),
    .busy  (mdu_busy),
    .done  (mdu_done),
    .result(mdu_result)
  );

  // Stall in IDLE (launch cycle) and RUN; released in DONE. Gated by reset so
  // an aborted operation stops holding the pipe immediately.
  assign Stall_E = rst & MulDiv_E & (mdu_busy | ~mdu_done);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWrite_M   <= 1'b0;
      MemWrite_M   <= 1'b0;
      ResultSrc_M  <= '0;
      RD_M         <= '0;
      PCPlus4_M    <= '0;
      WriteData_M  <= '0;
      ALU_Result_M <= '0;
    end else if (Stall_E) begin
      RegWrite_M   <= 1'b0;
      MemWrite_M   <= 1'b0;
      ResultSrc_M  <= '0;
      RD_M         <= '0;
      PCPlus4_M    <= '0;
      WriteData_M  <= '0;
      ALU_Result_M <= '0;
    end else begin
      RegWrite_M   <= RegWrite_E;
      MemWrite_M   <= MemWrite_E;
      ResultSrc_M  <= ResultSrc_E;
      RD_M         <= RD_E;
      PCPlus4_M    <= PCPlus4_E;
      WriteData_M  <= src_b_int;
      ALU_Result_M <= MulDiv_E ? mdu_result : alu_result;
    end
  end

endmodule

// File: tb/tb_execute_stage_mdu.sv
module tb_execute_stage_mdu;
  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;

  logic clk = 1'b0;
  logic rst;
  logic RegWrite_E, MemWrite_E, ALUSrc_E, Branch_E, Jump_E, Jalr_E, MulDiv_E;
  logic [1:0] ResultSrc_E, ForwardA_E, ForwardB_E;
  logic [3:0] ALUControl_E;
  logic [2:0] funct3_E;
  logic [XLEN-1:0] RD1_E, RD2_E, Imm_Ext_E, PC_E, PCPlus4_E, ResultW;
  logic [REGW-1:0] RD_E;
  logic PCSrc_E, Stall_E, RegWrite_M, MemWrite_M;
  logic [XLEN-1:0] PC_Target_E, PCPlus4_M, WriteData_M, ALU_Result_M;
  logic [1:0] ResultSrc_M;
  logic [REGW-1:0] RD_M;

  int n_cmp = 0;
  int n_err = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] exp_v;
  logic [4+REGW+3*XLEN-1:0] m_bus;

  always #5 clk = ~clk;

  assign m_bus = {RegWrite_M, MemWrite_M, ResultSrc_M, RD_M, PCPlus4_M, WriteData_M, ALU_Result_M};

  execute_stage_mdu #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E), .ALUSrc_E(ALUSrc_E),
    .Branch_E(Branch_E), .Jump_E(Jump_E), .Jalr_E(Jalr_E), .MulDiv_E(MulDiv_E),
    .ResultSrc_E(ResultSrc_E), .ALUControl_E(ALUControl_E), .funct3_E(funct3_E),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PC_E(PC_E),
    .PCPlus4_E(PCPlus4_E), .ResultW(ResultW), .RD_E(RD_E),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .PCSrc_E(PCSrc_E), .PC_Target_E(PC_Target_E), .Stall_E(Stall_E),
    .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M), .ResultSrc_M(ResultSrc_M),
    .RD_M(RD_M), .PCPlus4_M(PCPlus4_M), .WriteData_M(WriteData_M),
    .ALU_Result_M(ALU_Result_M)
  );

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return (sa < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return a << b[4:0];
      4'd8: return a >> b[4:0];
      4'd9: return sa >>> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mdu_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic signed [31:0] sa, sb;
    sa = a; sb = b;
    case (f3)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            else return sa / sb;
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) return a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            else return sa % sb;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic clear_inputs();
    RegWrite_E = 0; MemWrite_E = 0; ALUSrc_E = 0; Branch_E = 0; Jump_E = 0;
    Jalr_E = 0; MulDiv_E = 0; ResultSrc_E = 0; ALUControl_E = 0; funct3_E = 0;
    RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PC_E = 0; PCPlus4_E = 0; ResultW = 0;
    RD_E = 0; ForwardA_E = 2'b00; ForwardB_E = 2'b00;
  endtask

  task automatic drive_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    clear_inputs();
    ALUControl_E = op; RD1_E = a; RD2_E = b; RegWrite_E = 1; RD_E = 5'd3;
    PCPlus4_E = 32'h104;
    exp_q.push_back(alu_ref(op, a, b));
  endtask

  task automatic test_reset();
    drive_alu(4'd0, 32'd11, 32'd22);
    @(posedge clk); #1;
    rst = 0;
    #2;
    n_cmp++;
    if (m_bus !== '0) begin
      n_err++; $display("FAIL reset_m_outputs: got %h want 0", m_bus);
    end
    void'(exp_q.pop_front());
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    drive_alu(4'd0, 32'd5, 32'd7);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (ALU_Result_M !== exp_v || exp_v !== 32'd12) begin
      n_err++; $display("FAIL first_add: got %h want %h", ALU_Result_M, 32'd12);
    end
    n_cmp++;
    if ({RegWrite_M, RD_M, PCPlus4_M, WriteData_M} !== {1'b1, 5'd3, 32'h104, 32'd7}) begin
      n_err++; $display("FAIL first_add_fields: got %b %h %h %h", RegWrite_M, RD_M, PCPlus4_M, WriteData_M);
    end
  endtask

  task automatic test_alu();
    logic [31:0] a, b;
    for (int op = 0; op < 16; op++) begin
      for (int k = 0; k < 2; k++) begin
        a = (k == 0) ? 32'h8000_00F3 : $urandom;
        b = (k == 0) ? 32'h0000_0005 : $urandom;
        drive_alu(4'(op), a, b);
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (ALU_Result_M !== exp_v) begin
          n_err++; $display("FAIL alu_op%0d: a=%h b=%h got %h want %h", op, a, b, ALU_Result_M, exp_v);
        end
      end
    end
    // SRA through the immediate path
    clear_inputs();
    ALUControl_E = 4'd9; RD1_E = 32'h8000_0000; RD2_E = 32'd0; ALUSrc_E = 1; Imm_Ext_E = 32'd4;
    exp_q.push_back(32'hF800_0000);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (ALU_Result_M !== exp_v) begin
      n_err++; $display("FAIL sra_imm: got %h want %h", ALU_Result_M, exp_v);
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3s[6] = '{3'b100, 3'b110, 3'b000, 3'b001, 3'b010, 3'b011};
    logic       want[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      Branch_E = 1; funct3_E = f3s[i]; RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1;
      ALUSrc_E = 1; Imm_Ext_E = 32'h40; PC_E = 32'h100;
      #1;
      n_cmp++;
      if (PCSrc_E !== want[i] || PC_Target_E !== 32'h140) begin
        n_err++; $display("FAIL branch_f3_%b: got pcsrc=%b tgt=%h want pcsrc=%b tgt=%h",
                          f3s[i], PCSrc_E, PC_Target_E, want[i], 32'h140);
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    Jump_E = 1; Jalr_E = 1; RD1_E = 32'h1001; Imm_Ext_E = 32'd2; PC_E = 32'h500;
    #1;
    n_cmp++;
    if (PCSrc_E !== 1'b1 || PC_Target_E !== 32'h1002) begin
      n_err++; $display("FAIL jalr: got pcsrc=%b tgt=%h want 1 %h", PCSrc_E, PC_Target_E, 32'h1002);
    end
    @(posedge clk); #1;
  endtask

  // Drives an MDU op at cycle t; checks stall length, bubbles and the result.
  task automatic test_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic fwd_m, input logic [31:0] want);
    int stalls = 0;
    logic bubble_bad = 0;
    logic timed_out = 1;
    clear_inputs();
    MulDiv_E = 1; funct3_E = f3; RegWrite_E = 1; RD_E = 5'd9;
    RD1_E = fwd_m ? 32'hDEAD_0001 : a; RD2_E = b;
    ForwardA_E = fwd_m ? 2'b10 : 2'b00;
    exp_q.push_back(want);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!Stall_E) begin timed_out = 0; break; end
      stalls++;
      @(posedge clk); #1;
      if (RegWrite_M !== 1'b0 || ALU_Result_M !== '0) bubble_bad = 1;
      if (fwd_m && stalls == 2) ForwardA_E = 2'b00;
    end
    n_cmp++;
    if (timed_out) begin
      n_err++; $display("FAIL mdu_timeout_f3_%0d: got stall held want release", f3);
    end
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (ALU_Result_M !== exp_v || RegWrite_M !== 1'b1 || RD_M !== 5'd9) begin
      n_err++; $display("FAIL mdu_f3_%0d: a=%h b=%h got %h want %h", f3, a, b, ALU_Result_M, exp_v);
    end
    n_cmp++;
    if (stalls != 33 || bubble_bad) begin
      n_err++; $display("FAIL mdu_stall_f3_%0d: got %0d cycles bubble_bad=%b want 33 0", f3, stalls, bubble_bad);
    end
  endtask

  task automatic test_mdu_edges();
    test_mdu(3'd0, 32'd6, 32'd7, 0, 32'd42);
    test_mdu(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'd0);
    test_mdu(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE);
    test_mdu(3'd4, 32'd7, 32'd0, 0, 32'hFFFF_FFFF);
    test_mdu(3'd6, 32'd7, 32'd0, 0, 32'd7);
    test_mdu(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
    test_mdu(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0);
    test_mdu(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = (i == 5) ? 32'd0 : $urandom;
      if (i == 6) b = b >> 20;
      test_mdu(3'(i), a, b, 0, mdu_ref(3'(i), a, b));
    end
  endtask

  task automatic test_forward();
    drive_alu(4'd0, 32'd100, 32'd0);
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    test_mdu(3'd4, 32'd100, 32'd7, 1, 32'd14);
  endtask

  task automatic test_reset_mid_run();
    clear_inputs();
    MulDiv_E = 1; funct3_E = 3'd5; RD1_E = 32'd1000; RD2_E = 32'd3;
    repeat (6) @(posedge clk);
    #1;
    rst = 0;
    #1;
    n_cmp++;
    if (Stall_E !== 1'b0 || m_bus !== '0) begin
      n_err++; $display("FAIL reset_mid_run: got stall=%b m=%h want 0 0", Stall_E, m_bus);
    end
    @(negedge clk);
    clear_inputs();
    rst = 1;
    @(posedge clk); #1;
    test_mdu(3'd0, 32'd6, 32'd7, 0, 32'd42);
  endtask

  initial begin
    rst = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (m_bus !== '0 || Stall_E !== 1'b0) begin
      n_err++; $display("FAIL power_on_reset: got m=%h stall=%b want 0", m_bus, Stall_E);
    end
    rst = 1;
    @(posedge clk); #1;
    test_reset();
    test_alu();
    test_branch();
    test_mdu_edges();
    test_back_to_back();
    test_forward();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
